// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: shared prescaled timebase (edge- or center-aligned)
// driving CHANNELS comparators with double-buffered period and duty registers.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      center_mode,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS-1:0]       duty_wr,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       update_pend
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH-1:0]   counter;
    logic [WIDTH-1:0]   p_act;
    logic               count_down;
    logic               running;
    logic [WIDTH-1:0]   active_duty [CHANNELS];
    logic [WIDTH-1:0]   pend_duty   [CHANNELS];

    logic               tick;
    logic               boundary;
    logic               load_shadow;
    logic [WIDTH-1:0]   cnt_next;
    logic               dir_next;

    assign tick        = (presc_cnt == prescale);
    assign load_shadow = ~enable | boundary;

    // A boundary is any tick that reloads the counter with 0; the first tick
    // after enable rises is forced to be one so a restart always opens a fresh period.
    always_comb begin
        cnt_next = counter;
        dir_next = count_down;
        boundary = 1'b0;
        if (tick) begin
            if (!running || p_act == '0) begin
                boundary = 1'b1;
            end else if (!center_mode) begin
                if (counter >= p_act) begin
                    boundary = 1'b1;
                end else begin
                    cnt_next = counter + WIDTH'(1);
                end
            end else begin
                if (!count_down && counter < p_act) begin
                    cnt_next = counter + WIDTH'(1);
                end else begin
                    cnt_next = counter - WIDTH'(1);
                    dir_next = 1'b1;
                end
                if (cnt_next == '0) begin
                    boundary = 1'b1;
                end
            end
            if (boundary) begin
                cnt_next = '0;
                dir_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt    <= '0;
            counter      <= '0;
            p_act        <= '0;
            count_down   <= 1'b0;
            running      <= 1'b0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            update_pend  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                active_duty[i] <= '0;
                pend_duty[i]   <= '0;
            end
        end else begin
            if (!enable) begin
                presc_cnt    <= '0;
                counter      <= '0;
                count_down   <= 1'b0;
                running      <= 1'b0;
                pwm_out      <= '0;
                period_start <= 1'b0;
            end else begin
                presc_cnt    <= tick ? '0 : presc_cnt + PRESC_W'(1);
                counter      <= cnt_next;
                count_down   <= dir_next;
                period_start <= boundary;
                if (tick) begin
                    running <= 1'b1;
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    pwm_out[i] <= (active_duty[i] > counter);
                end
            end

            if (load_shadow) begin
                p_act <= period;
            end
            // A write landing on a boundary stays pending: the boundary consumes the old value.
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_shadow && update_pend[i]) begin
                    active_duty[i] <= pend_duty[i];
                end
                if (duty_wr[i]) begin
                    pend_duty[i] <= duty_in[i*WIDTH +: WIDTH];
                end
                update_pend[i] <= duty_wr[i] | (update_pend[i] & ~load_shadow);
            end
        end
    end

endmodule
